scanchain_arbiter: RTL and testbench
====================================

Name: scanchain_arbiter

Overview:
- Shares the single scan chain writer between NUM_REQ independent requesters (e.g. UART command path, boot-time config sequencer, debug core).
- Round-robin arbitration grants one requester at a time and forwards its address, payload and reset flag to the writer's valid/ready port.
- Tracks each transaction until the writer finishes, then pulses a per-requester done.
- Sits between the requester fabric and the scan chain writer, on the same clock.

Parameters:
- NUM_REQ, 2, number of requesters (>=2).
- ADDR_BITS, 12, scan chain address width; must match the writer.
- PAYLOAD_BITS, 169, scan chain payload width; must match the writer.
- Derived: ID_BITS = $clog2(NUM_REQ).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero.
- req_addr  in  NUM_REQ*ADDR_BITS  packed addresses; requester i uses slice [i*ADDR_BITS +: ADDR_BITS].
- req_payload  in  NUM_REQ*PAYLOAD_BITS  packed payloads, sliced the same way.
- req_reset  in  NUM_REQ  per-requester scan_reset request.
- req_done  out  NUM_REQ  one-cycle completion pulse to the owning requester.
- write_ready  in  1  from writer.
- write_valid  out  1  to writer.
- write_addr  out  ADDR_BITS  to writer.
- write_payload  out  PAYLOAD_BITS  to writer.
- write_reset  out  1  to writer.
- busy  out  1  high in any state other than IDLE.
- grant_id  out  ID_BITS  index of the current or last granted requester.
- txn_count  out  16  present only with SCANCHAIN_ARB_STATS_EN.

Behaviour:
- Reset is asynchronous and active-high. On reset:
  - State goes to IDLE.
  - write_valid=0, write_addr=0, write_payload=0, write_reset=0.
  - req_done=0, busy=0, grant_id=0.
  - Round-robin pointer last=NUM_REQ-1, so requester 0 has first priority.
  - txn_count=0.
- States: IDLE -> ISSUE -> WAIT_BUSY -> WAIT_DONE -> ACK -> IDLE.
- IDLE:
  - Winner w is the first i with req_valid[i]=1, searching cyclically from last+1.
  - req_ready is combinational: req_ready[w]=1 only in IDLE with some req_valid set; all other bits 0.
  - On req_valid[w]&req_ready[w]: register addr, payload, reset flag and grant_id=w; set last=w; go to ISSUE.
  - write_valid rises the next cycle (1-cycle accept-to-valid latency).
- ISSUE:
  - write_valid=1, write_* held stable.
  - On write_valid&write_ready: drop write_valid next cycle; go to WAIT_BUSY.
- WAIT_BUSY: wait for write_ready=0, i.e. writer internalized the request; go to WAIT_DONE.
- WAIT_DONE: wait for write_ready=1, i.e. shift complete and scan_en low; go to ACK.
- ACK:
  - req_done[grant_id]=1 for exactly one cycle; increment txn_count.
  - Go to IDLE. The next grant is possible on the cycle after ACK.
- Requester rules:
  - req_valid must not depend on req_ready.
  - Requester inputs are sampled only at acceptance; later changes are ignored.
  - A requester that deasserts req_valid before being accepted is simply skipped.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NUM_REQ-1,0. No requester waits more than NUM_REQ-1 transactions.
- Single requester: it is granted back-to-back, each transaction separated by the ACK and IDLE cycles.
- write_ready already high entering ISSUE: handshake completes in that same cycle.
- write_ready=0 at entry to ISSUE (writer still busy from another cause): write_valid is held until ready.
- Reset asserted mid-transaction: immediate return to IDLE with no req_done issued.
  - The writer shares the reset, so no partial scan continues.
  - Requesters must re-request.
- write_* outputs hold their last value in IDLE; consumers qualify them only with write_valid.

Optional Feature:
- Macro: SCANCHAIN_ARB_STATS_EN.
- Defined:
  - txn_count port exists: 16-bit count of completed transactions (ACK cycles).
  - Saturates at 16'hFFFF, does not wrap.
  - Cleared only by reset.
- Undefined: txn_count port and its counter are absent. All other behaviour is identical.

Test Plan:
- Bench setup: ADDR_BITS=4, PAYLOAD_BITS=8, NUM_REQ=3. Behavioural writer model drops ready 1 cycle after accept and holds it low 20 cycles.
- Single request, req0 addr=4'hA payload=8'h5C reset=1:
  - req_ready[0] same cycle; write_valid next cycle with addr=A, payload=5C, write_reset=1.
  - req_done[0] pulses once, after write_ready returns high.
- All three valid continuously for 6 transactions -> grant_id sequence 0,1,2,0,1,2; each req_done bit pulses exactly twice.
- Writer ready held low 5 cycles in ISSUE -> write_valid stays high with stable data; exactly one accept.
- Async reset asserted in WAIT_DONE:
  - busy=0 and write_valid=0 immediately, without a clock edge.
  - No req_done; the next request is granted to req0.
- Requester changes req_payload after acceptance -> writer sees the originally captured payload.
- With SCANCHAIN_ARB_STATS_EN:
  - 5 transactions -> txn_count=5.
  - Counter forced to 16'hFFFE plus 3 transactions -> txn_count=16'hFFFF.

Source files
------------

// File: rtl/scanchain_arbiter.sv
// Round-robin arbiter sharing one scan chain writer among NUM_REQ requesters; optional SCANCHAIN_ARB_STATS_EN adds txn_count.
// Latency: accept -> write_valid 1 cycle; req_done pulses the cycle after the writer returns ready.
// Backpressure: write_valid holds until write_ready; no requester is accepted until the previous transaction is acked.
module scanchain_arbiter #(
    parameter int NUM_REQ      = 2,
    parameter int ADDR_BITS    = 12,
    parameter int PAYLOAD_BITS = 169,
    parameter int ID_BITS      = $clog2(NUM_REQ)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ*ADDR_BITS-1:0]    req_addr,
    input  logic [NUM_REQ*PAYLOAD_BITS-1:0] req_payload,
    input  logic [NUM_REQ-1:0]              req_reset,
    output logic [NUM_REQ-1:0]              req_done,
    input  logic                            write_ready,
    output logic                            write_valid,
    output logic [ADDR_BITS-1:0]            write_addr,
    output logic [PAYLOAD_BITS-1:0]         write_payload,
    output logic                            write_reset,
    output logic                            busy,
    output logic [ID_BITS-1:0]              grant_id
`ifdef SCANCHAIN_ARB_STATS_EN
    ,
    output logic [15:0]                     txn_count
`endif
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ISSUE     = 3'd1;
    localparam logic [2:0] S_WAIT_BUSY = 3'd2;
    localparam logic [2:0] S_WAIT_DONE = 3'd3;
    localparam logic [2:0] S_ACK       = 3'd4;

    localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

    logic [2:0]              state_q, state_d;
    logic [ID_BITS-1:0]      last_q, last_d;
    logic [ID_BITS-1:0]      grant_q, grant_d;
    logic [ADDR_BITS-1:0]    addr_q, addr_d;
    logic [PAYLOAD_BITS-1:0] payload_q, payload_d;
    logic                    rst_q, rst_d;

    logic                    win_vld;
    logic [ID_BITS-1:0]      win_id;

    // Cyclic search starting just after the last winner.
    always_comb begin
        int cand;
        cand    = 0;
        win_vld = 1'b0;
        win_id  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(last_q) + k) % NUM_REQ;
            if (!win_vld && req_valid[cand]) begin
                win_vld = 1'b1;
                win_id  = ID_BITS'(cand);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        grant_d   = grant_q;
        addr_d    = addr_q;
        payload_d = payload_q;
        rst_d     = rst_q;
        case (state_q)
            S_IDLE: begin
                if (win_vld) begin
                    state_d   = S_ISSUE;
                    last_d    = win_id;
                    grant_d   = win_id;
                    addr_d    = req_addr[win_id*ADDR_BITS +: ADDR_BITS];
                    payload_d = req_payload[win_id*PAYLOAD_BITS +: PAYLOAD_BITS];
                    rst_d     = req_reset[win_id];
                end
            end
            S_ISSUE:     if (write_ready)  state_d = S_WAIT_BUSY;
            S_WAIT_BUSY: if (!write_ready) state_d = S_WAIT_DONE;
            S_WAIT_DONE: if (write_ready)  state_d = S_ACK;
            S_ACK:                         state_d = S_IDLE;
            default:                       state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            last_q    <= ID_BITS'(NUM_REQ - 1);
            grant_q   <= '0;
            addr_q    <= '0;
            payload_q <= '0;
            rst_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            grant_q   <= grant_d;
            addr_q    <= addr_d;
            payload_q <= payload_d;
            rst_q     <= rst_d;
        end
    end

    // Outputs decode straight from state so an async reset clears them without a clock.
    assign req_ready     = (state_q == S_IDLE && win_vld) ? (ONE_HOT0 << win_id) : '0;
    assign req_done      = (state_q == S_ACK) ? (ONE_HOT0 << grant_q) : '0;
    assign write_valid   = (state_q == S_ISSUE);
    assign write_addr    = addr_q;
    assign write_payload = payload_q;
    assign write_reset   = rst_q;
    assign busy          = (state_q != S_IDLE);
    assign grant_id      = grant_q;

`ifdef SCANCHAIN_ARB_STATS_EN
    logic [15:0] txn_count_q, txn_count_d;

    always_comb begin
        txn_count_d = txn_count_q;
        if (state_q == S_ACK && txn_count_q != 16'hFFFF) txn_count_d = txn_count_q + 16'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) txn_count_q <= '0;
        else       txn_count_q <= txn_count_d;
    end

    assign txn_count = txn_count_q;
`endif

endmodule

// File: tb/tb_scanchain_arbiter.sv
// Bench for scanchain_arbiter: reference arbiter model feeds a scoreboard checked at the writer port and req_done.
module tb_scanchain_arbiter;

    localparam int NR = 3;
    localparam int AB = 4;
    localparam int PB = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR-1:0]     req_valid, req_ready, req_reset, req_done;
    logic [NR*AB-1:0]  req_addr;
    logic [NR*PB-1:0]  req_payload;
    logic              write_ready, write_valid, write_reset, busy;
    logic [AB-1:0]     write_addr;
    logic [PB-1:0]     write_payload;
    logic [1:0]        grant_id;
`ifdef SCANCHAIN_ARB_STATS_EN
    logic [15:0]       txn_count;
`endif

    scanchain_arbiter #(.NUM_REQ(NR), .ADDR_BITS(AB), .PAYLOAD_BITS(PB)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_payload(req_payload),
        .req_reset(req_reset), .req_done(req_done),
        .write_ready(write_ready), .write_valid(write_valid),
        .write_addr(write_addr), .write_payload(write_payload),
        .write_reset(write_reset), .busy(busy), .grant_id(grant_id)
`ifdef SCANCHAIN_ARB_STATS_EN
        , .txn_count(txn_count)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Writer model: drops ready one cycle after accept, low for 20 cycles.
    logic wr_rdy_q, wr_pend, wr_block;
    int   wr_cnt;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_rdy_q <= 1'b1; wr_pend <= 1'b0; wr_cnt <= 0;
        end else begin
            wr_pend <= write_valid && write_ready;
            if (wr_pend) begin
                wr_rdy_q <= 1'b0; wr_cnt <= 20;
            end else if (wr_cnt > 1) begin
                wr_cnt <= wr_cnt - 1;
            end else if (wr_cnt == 1) begin
                wr_cnt <= 0; wr_rdy_q <= 1'b1;
            end
        end
    end
    assign write_ready = wr_rdy_q && !wr_block;

    typedef struct {
        int           id;
        logic [AB-1:0] addr;
        logic [PB-1:0] pay;
        logic          rst;
    } txn_t;

    txn_t exp_q[$];
    int   done_q[$];
    int   grant_log[$];
    int   done_cnt[NR];
    int   done_total = 0;
    int   done_since_rst = 0;
    int   accepts = 0;

    // Reference model: idle arbiter grants first valid requester after the last winner.
    int m_last = NR - 1;
    bit m_busy = 0, m_issue = 0, m_saw_low = 0;
    int m_busy_cnt = 0;
    always @(negedge clk) begin
        logic [NR-1:0] exp_rdy;
        int w;
        txn_t t;
        if (reset) begin
            m_last = NR - 1; m_busy = 0; m_issue = 0; m_saw_low = 0; m_busy_cnt = 0;
            exp_q.delete(); done_q.delete();
        end else begin
            chk("busy", busy, m_busy);
            chk("write_valid", write_valid, m_issue);
            exp_rdy = '0;
            w = -1;
            if (!m_busy) begin
                for (int k = 1; k <= NR; k++) begin
                    if (w < 0 && req_valid[(m_last + k) % NR]) w = (m_last + k) % NR;
                end
            end
            if (w >= 0) exp_rdy[w] = 1'b1;
            chk("req_ready", req_ready, exp_rdy);
            if (m_issue && write_valid && write_ready) m_issue = 0;
            if (m_busy && !m_issue && !write_ready) m_saw_low = 1;
            if (req_done != '0) begin
                chk("done_after_writer", m_saw_low, 1);
                m_busy = 0; m_saw_low = 0; m_busy_cnt = 0;
            end
            if (m_busy) begin
                m_busy_cnt++;
                if (m_busy_cnt > 400) begin
                    chk("txn_timeout", m_busy_cnt, 0);
                    m_busy = 0; m_issue = 0; m_busy_cnt = 0;
                end
            end
            if (w >= 0) begin
                t.id = w; t.addr = req_addr[w*AB +: AB]; t.pay = req_payload[w*PB +: PB]; t.rst = req_reset[w];
                exp_q.push_back(t);
                done_q.push_back(w);
                m_last = w; m_busy = 1; m_issue = 1;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a writer handshake or a done pulse.
    always @(negedge clk) begin
        txn_t t;
        logic [NR-1:0] oh;
        int d;
        if (reset) begin
            done_since_rst = 0;
        end else begin
            if (write_valid && write_ready) begin
                accepts++;
                grant_log.push_back(int'(grant_id));
                if (exp_q.size() == 0) chk("unexpected_write", 1, 0);
                else begin
                    t = exp_q.pop_front();
                    chk("write_addr", write_addr, t.addr);
                    chk("write_payload", write_payload, t.pay);
                    chk("write_reset", write_reset, t.rst);
                    chk("grant_id", grant_id, t.id);
                end
            end
            if (req_done != '0) begin
                done_total++; done_since_rst++;
                if (done_q.size() == 0) chk("unexpected_done", req_done, 0);
                else begin
                    d = done_q.pop_front();
                    oh = '0; oh[d] = 1'b1;
                    chk("req_done", req_done, oh);
                    done_cnt[d]++;
                end
            end
        end
    end

    task automatic apply_reset();
        @(posedge clk); #2;
        reset = 1'b1; req_valid = '0;
        #1;
        chk("rst_write_valid", write_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_req_done", req_done, 0);
        chk("rst_write_addr", write_addr, 0);
        chk("rst_write_payload", write_payload, 0);
        chk("rst_write_reset", write_reset, 0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
    endtask

    task automatic wait_done(input string name, input int target, input int budget);
        int n = 0;
        while (done_total < target && n < budget) begin
            @(negedge clk); #1; n++;
        end
        chk(name, done_total >= target, 1);
    endtask

    task automatic one_txn(input int id);
        int d0 = done_total;
        @(posedge clk); #1 req_valid = '0; req_valid[id] = 1'b1;
        @(posedge clk); #1 req_valid = '0;
        wait_done("one_txn_wait", d0 + 1, 100);
    endtask

    initial begin
        int d0, g0, a0, n;
        reset = 1'b1; req_valid = '0; req_addr = '0; req_payload = '0; req_reset = '0; wr_block = 1'b0;
        for (int i = 0; i < NR; i++) done_cnt[i] = 0;
        apply_reset();

        // Single request from requester 0.
        @(posedge clk); #1;
        req_valid = 3'b001; req_addr = 12'h00A; req_payload = 24'h00005C; req_reset = 3'b001;
        @(negedge clk);
        chk("single_ready_same_cycle", req_ready, 3'b001);
        @(posedge clk); #1;
        req_valid = '0; req_payload = 24'hFFFFFF; req_reset = '0;
        @(negedge clk);
        chk("single_wv", write_valid, 1);
        chk("single_addr", write_addr, 4'hA);
        chk("single_payload", write_payload, 8'h5C);
        chk("single_reset", write_reset, 1);
        wait_done("single_done_wait", 1, 100);
        repeat (5) @(negedge clk);
        chk("single_done_once", done_cnt[0], 1);
        chk("single_grant_hold", grant_id, 0);

        // Fairness with all three continuously valid.
        apply_reset();
        for (int i = 0; i < NR; i++) done_cnt[i] = 0;
        g0 = grant_log.size(); d0 = done_total;
        @(posedge clk); #1;
        req_valid = 3'b111; req_addr = 12'h321; req_payload = 24'hC3B2A1; req_reset = 3'b010;
        wait_done("fair_wait", d0 + 6, 300);
        @(posedge clk); #1 req_valid = '0;
        for (int k = 0; k < 6; k++) chk("fair_order", grant_log[g0 + k], k % 3);
        for (int i = 0; i < NR; i++) chk("fair_done_count", done_cnt[i], 2);

        // Writer stalls in ISSUE; inputs change after acceptance.
        @(posedge clk); #1;
        wr_block = 1'b1; req_valid = 3'b001; req_addr = 12'h003; req_payload = 24'h0000C3; req_reset = '0;
        @(posedge clk); #1;
        req_valid = '0; req_payload = 24'h111111; req_addr = 12'hFFF;
        a0 = accepts; d0 = done_total;
        repeat (5) begin
            @(negedge clk);
            chk("stall_wv", write_valid, 1);
            chk("stall_payload", write_payload, 8'hC3);
            chk("stall_addr", write_addr, 4'h3);
        end
        @(posedge clk); #1 wr_block = 1'b0;
        wait_done("stall_done_wait", d0 + 1, 100);
        chk("stall_one_accept", accepts, a0 + 1);

        // Async reset while waiting for the shift to finish.
        @(posedge clk); #1 req_valid = 3'b010;
        @(posedge clk); #1 req_valid = '0;
        repeat (6) @(posedge clk);
        #3;
        chk("pre_rst_busy", busy, 1);
        d0 = done_total;
        reset = 1'b1;
        #1;
        chk("async_busy", busy, 0);
        chk("async_wv", write_valid, 0);
        chk("async_done", req_done, 0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        @(posedge clk); #1 req_valid = 3'b111;
        @(negedge clk);
        chk("post_rst_ready", req_ready, 3'b001);
        chk("post_rst_no_done", done_total, d0);
        @(posedge clk); #1 req_valid = '0;
        wait_done("post_rst_wait", d0 + 1, 100);

        // Randomised traffic.
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < NR; i++) begin
                req_valid[i] = ($urandom_range(0, 99) < 50);
                req_reset[i] = $urandom_range(0, 1);
                req_addr[i*AB +: AB] = AB'($urandom);
                req_payload[i*PB +: PB] = PB'($urandom);
            end
            wr_block = ($urandom_range(0, 99) < 10);
        end
        @(posedge clk); #1 req_valid = '0; wr_block = 1'b0;
        n = 0;
        while (busy && n < 200) begin @(negedge clk); n++; end
        chk("drain_idle", busy, 0);

`ifdef SCANCHAIN_ARB_STATS_EN
        apply_reset();
        repeat (5) one_txn(1);
        @(negedge clk);
        chk("stats_five", txn_count, 16'd5);
        force dut.txn_count_q = 16'hFFFE;
        @(posedge clk); #1;
        release dut.txn_count_q;
        repeat (3) one_txn(2);
        @(negedge clk);
        chk("stats_saturate", txn_count, 16'hFFFF);
`endif

        repeat (3) @(negedge clk);
        chk("exp_queue_empty", exp_q.size(), 0);
        chk("done_queue_empty", done_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
